sa_fm_feeder: RTL and testbench

- Producer side of the systolic-array control handshake.
- Streams feature-map words from the on-chip FM buffer into the SA, one tile at a time.
- Issues the one-cycle re_fm_en start pulse that the SA controller uses to launch its self-timed pixel count.
- Waits for the controller's end-of-drain indication before starting the next tile; signals done after the last tile.

---
 rtl/sa_fm_feeder.sv | 106 ++++++++++
 tb/tb_sa_fm_feeder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sa_fm_feeder.sv
// sa_fm_feeder: streams FM buffer tiles into the systolic array, pacing each tile on the controller's tile_done
module sa_fm_feeder #(
  parameter int ADDR_W = 16,
  parameter int TILE_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       nif_mult_k_mult_k,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              fm_buf_ready,
  input  logic              tile_done,
  output logic              fm_rd_en,
  output logic [ADDR_W-1:0] fm_rd_addr,
  output logic              fm_word_valid,
  output logic              re_fm_en,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, CHECK, STREAM, DRAIN} state_t;
  if (RD_LAT != 1) begin : g_rd_lat
    $error("sa_fm_feeder only supports RD_LAT == 1");
  end
  state_t state, state_d;
  logic [31:0] w_m1, w_m1_d, cnt, cnt_d;
  logic [TILE_W-1:0] nt, nt_d, tile_idx_d;
  logic [ADDR_W-1:0] next_addr, next_addr_d, fm_rd_addr_d;
  logic fm_rd_en_d, done_d, err_d;
  assign busy = state != IDLE;
  // next state and next values of every registered output; cnt counts reads still owed after the current one
  always_comb begin
    state_d = state;
    w_m1_d = w_m1;
    nt_d = nt;
    cnt_d = cnt;
    next_addr_d = next_addr;
    tile_idx_d = tile_idx;
    fm_rd_en_d = 1'b0;
    fm_rd_addr_d = fm_rd_addr;
    done_d = 1'b0;
    err_d = err | (tile_done & (state != DRAIN));
    case (state)
      IDLE: if (start) begin
        w_m1_d = nif_mult_k_mult_k;
        nt_d = num_tiles;
        next_addr_d = base_addr;
        tile_idx_d = '0;
        done_d = num_tiles == '0;
        state_d = num_tiles == '0 ? IDLE : CHECK;
      end
      CHECK: if (fm_buf_ready) begin
        state_d = STREAM;
        fm_rd_en_d = 1'b1;
        fm_rd_addr_d = next_addr;
        cnt_d = w_m1;
      end
      STREAM: if (cnt != 32'd0) begin
        fm_rd_en_d = 1'b1;
        fm_rd_addr_d = fm_rd_addr + ADDR_W'(1);
        cnt_d = cnt - 32'd1;
      end else begin
        next_addr_d = fm_rd_addr + ADDR_W'(1);
        state_d = DRAIN;
      end
      DRAIN: if (tile_done) begin
        done_d = tile_idx == nt - TILE_W'(1);
        tile_idx_d = tile_idx == nt - TILE_W'(1) ? tile_idx : tile_idx + TILE_W'(1);
        state_d = tile_idx == nt - TILE_W'(1) ? IDLE : CHECK;
      end
    endcase
  end
  // state and output registers; word_valid trails the read strobe by the buffer latency and re_fm_en marks the first word of a burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      w_m1 <= '0;
      nt <= '0;
      cnt <= '0;
      next_addr <= '0;
      tile_idx <= '0;
      fm_rd_en <= 1'b0;
      fm_rd_addr <= '0;
      fm_word_valid <= 1'b0;
      re_fm_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      w_m1 <= w_m1_d;
      nt <= nt_d;
      cnt <= cnt_d;
      next_addr <= next_addr_d;
      tile_idx <= tile_idx_d;
      fm_rd_en <= fm_rd_en_d;
      fm_rd_addr <= fm_rd_addr_d;
      fm_word_valid <= fm_rd_en;
      re_fm_en <= fm_rd_en & ~fm_word_valid;
      done <= done_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_sa_fm_feeder.sv
// tb_sa_fm_feeder: randomized jobs against an address-list model of the feeder plus directed corner cases
module tb_sa_fm_feeder;
  logic clk = 0, reset = 1, start = 0, fm_buf_ready = 1, tile_done = 0;
  logic [31:0] nif = 0;
  logic [15:0] num_tiles = 0, base_addr = 0;
  logic fm_rd_en, fm_word_valid, re_fm_en, busy, done, err;
  logic [15:0] fm_rd_addr, tile_idx;
  int tests = 0, fails = 0, cyc = 0;
  int re_cnt = 0, done_cnt = 0, burst_cnt = 0, align_err = 0;
  logic p1 = 0, p2 = 0;
  logic [15:0] rd_q[$];
  int rd_cyc_q[$];

  sa_fm_feeder #(.ADDR_W(16), .TILE_W(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .nif_mult_k_mult_k(nif),
    .num_tiles(num_tiles), .base_addr(base_addr), .fm_buf_ready(fm_buf_ready),
    .tile_done(tile_done), .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
    .fm_word_valid(fm_word_valid), .re_fm_en(re_fm_en), .tile_idx(tile_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // logs every read and checks the buffer alignment rule: valid one cycle after each read, re_fm_en one cycle after a burst's first read
  always @(negedge clk) begin
    if (reset) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      if (fm_rd_en) begin
        rd_q.push_back(fm_rd_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (fm_rd_en && !p1) burst_cnt <= burst_cnt + 1;
      re_cnt <= re_cnt + int'(re_fm_en);
      done_cnt <= done_cnt + int'(done);
      if (fm_word_valid !== p1 || re_fm_en !== (p1 && !p2)) align_err <= align_err + 1;
      p1 <= fm_rd_en;
      p2 <= p1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 300 && rd_q.size() < n; i++) tick();
    chk("wait_reads", rd_q.size(), n);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    chk("done_cnt", done_cnt - d0, 1);
  endtask

  // model: a job reads nt*W contiguous addresses from base (mod 2^16), in nt bursts of W, each gated by tile_done
  task automatic run_job(input int wm1, input int nt, input logic [15:0] base, input int dly, input bit inj);
    int r0, e0, d0, b0, w, bad;
    logic [15:0] ea;
    w = wm1 + 1;
    r0 = rd_q.size(); e0 = re_cnt; d0 = done_cnt; b0 = burst_cnt; bad = 0;
    nif = wm1; num_tiles = 16'(nt); base_addr = base; start = 1;
    tick();
    start = 0;
    for (int t = 0; t < nt; t++) begin
      wait_reads(r0 + (t + 1) * w);
      chk("tile_idx", tile_idx, t);
      if (inj && t == 0) begin
        nif = 3; num_tiles = 2; base_addr = 16'h5555; start = 1;
        tick();
        start = 0;
      end
      repeat (dly) tick();
      chk("tile_gated", rd_q.size() - r0, (t + 1) * w);
      tile_done = 1;
      tick();
      tile_done = 0;
    end
    wait_done(d0);
    chk("busy_end", busy, 0);
    chk("reads", rd_q.size() - r0, nt * w);
    for (int i = 0; i < nt * w && r0 + i < rd_q.size(); i++) begin
      ea = base + 16'(i);
      if (rd_q[r0 + i] !== ea) bad++;
    end
    chk("addr_seq", bad, 0);
    chk("re_pulses", re_cnt - e0, nt);
    chk("bursts", burst_cnt - b0, nt);
    chk("tile_idx_final", tile_idx, nt - 1);
    chk("err_clean", err, 0);
  endtask

  initial begin
    int r0, d0, c;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {fm_rd_en, re_fm_en, fm_word_valid, busy, done, err, tile_idx, fm_rd_addr}, 0);
    reset = 0;
    tick();
    run_job(8, 1, 16'h0100, 40, 0);
    run_job(3, 3, 16'h0000, 5, 0);
    fm_buf_ready = 0;
    r0 = rd_q.size(); d0 = done_cnt;
    nif = 2; num_tiles = 1; base_addr = 16'h0200; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    chk("ready_low_no_reads", rd_q.size() - r0, 0);
    chk("busy_in_check", busy, 1);
    fm_buf_ready = 1;
    c = cyc;
    wait_reads(r0 + 3);
    chk("first_rd_cycle", rd_cyc_q[r0], c + 1);
    chk("first_rd_addr", rd_q[r0], 16'h0200);
    tile_done = 1;
    tick();
    tile_done = 0;
    wait_done(d0);
    run_job(3, 1, 16'hFFFE, 3, 0);
    r0 = rd_q.size();
    nif = 5; num_tiles = 0; start = 1;
    tick();
    start = 0;
    chk("done_zero_tiles", done, 1);
    chk("busy_zero_tiles", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    repeat (5) tick();
    chk("zero_tiles_reads", rd_q.size() - r0, 0);
    run_job(2, 2, 16'h0040, 4, 1);
    run_job(0, 2, 16'h1234, 0, 0);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 10), $urandom_range(1, 4), 16'($urandom), $urandom_range(0, 30), 0);
    r0 = rd_q.size(); d0 = done_cnt;
    nif = 7; num_tiles = 1; base_addr = 16'h0300; start = 1;
    tick();
    start = 0;
    wait_reads(r0 + 2);
    tile_done = 1;
    tick();
    tile_done = 0;
    tick();
    chk("err_set", err, 1);
    wait_reads(r0 + 8);
    repeat (3) tick();
    chk("err_sticky", err, 1);
    chk("stream_complete", rd_q.size() - r0, 8);
    tile_done = 1;
    tick();
    tile_done = 0;
    wait_done(d0);
    r0 = rd_q.size();
    nif = 15; num_tiles = 2; base_addr = 0; start = 1;
    tick();
    start = 0;
    wait_reads(r0 + 1);
    #2 reset = 1;
    #1 chk("async_reset", {fm_rd_en, re_fm_en, busy, err}, 0);
    #10 reset = 0;
    tick();
    run_job(1, 1, 16'h0010, 2, 0);
    chk("align", align_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
